// File: rtl/jump_stack_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jump_stack_unit                                            |
// | Description : Branch/jump resolution unit with a circular return-address |
// |               stack. One operation per cycle with ena=1; the next PC,    |
// |               taken and illegal flags appear one cycle later.            |
// | Ports       : clk, rst_n (sync, active-low), ena, func[3:0],             |
// |               addr[ADDR_W], carryFlag/signFlag/overflowFlag/zeroFlag,    |
// |               PC[PC_W] -> PC_new[PC_W], valid, taken, ra_top[PC_W],      |
// |               ras_empty, ras_full, ras_ovf, ras_unf, illegal             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jump_stack_unit #(
   parameter int ADDR_W    = 22,
   parameter int PC_W      = 32,
   parameter int RAS_DEPTH = 8,
   parameter int REL_MODE  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [3:0]        func,
   input  logic [ADDR_W-1:0] addr,
   input  logic              carryFlag,
   input  logic              signFlag,
   input  logic              overflowFlag,
   input  logic              zeroFlag,
   input  logic [PC_W-1:0]   PC,
   output logic [PC_W-1:0]   PC_new,
   output logic              valid,
   output logic              taken,
   output logic [PC_W-1:0]   ra_top,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf,
   output logic              illegal
);

   localparam int SP_W  = $clog2(RAS_DEPTH);
   localparam int CNT_W = SP_W + 1;

   localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(RAS_DEPTH);

   localparam logic [3:0] C_CALL   = 4'd0;
   localparam logic [3:0] C_BNO    = 4'd1;
   localparam logic [3:0] C_BO     = 4'd2;
   localparam logic [3:0] C_BNS    = 4'd3;
   localparam logic [3:0] C_BS     = 4'd4;
   localparam logic [3:0] C_BNC    = 4'd5;
   localparam logic [3:0] C_BC     = 4'd6;
   localparam logic [3:0] C_BNZ    = 4'd7;
   localparam logic [3:0] C_BZ     = 4'd8;
   localparam logic [3:0] C_JMP    = 4'd9;
   localparam logic [3:0] C_RET    = 4'd10;
   localparam logic [3:0] C_CLRERR = 4'd11;

   logic [PC_W-1:0]  stack [RAS_DEPTH];
   logic [SP_W-1:0]  sp;
   logic [SP_W-1:0]  sp_m1;
   logic [CNT_W-1:0] count;
   logic [PC_W-1:0]  pc_inc;
   logic [PC_W-1:0]  target;
   logic             cond_met;
   logic             stack_nonempty;

   assign pc_inc         = PC + PC_W'(1);
   assign sp_m1          = sp - SP_W'(1);   // wraps naturally: power-of-two depth
   assign stack_nonempty = (count != '0);

   // Target formation: absolute (zero-extended) or PC-relative (sign-extended
   // offset). An addr wider than PC is cut down to the PC width first.
   generate
      if (REL_MODE == 1) begin : g_rel
         if (ADDR_W >= PC_W) begin : g_trunc
            assign target = PC + addr[PC_W-1:0];
         end else begin : g_sext
            assign target = PC + {{(PC_W-ADDR_W){addr[ADDR_W-1]}}, addr};
         end
      end else begin : g_abs
         if (ADDR_W >= PC_W) begin : g_trunc
            assign target = addr[PC_W-1:0];
         end else begin : g_zext
            assign target = {{(PC_W-ADDR_W){1'b0}}, addr};
         end
      end
   endgenerate

   always_comb begin
      cond_met = 1'b0;
      case (func)
         C_BNO:   cond_met = ~overflowFlag;
         C_BO:    cond_met =  overflowFlag;
         C_BNS:   cond_met = ~signFlag;
         C_BS:    cond_met =  signFlag;
         C_BNC:   cond_met = ~carryFlag;
         C_BC:    cond_met =  carryFlag;
         C_BNZ:   cond_met = ~zeroFlag;
         C_BZ:    cond_met =  zeroFlag;
         default: cond_met = 1'b0;
      endcase
   end

   // Stack storage is not reset; the count register alone makes stale
   // entries unobservable after reset.
   always_ff @(posedge clk) begin
      if (rst_n && ena && (func == C_CALL)) begin
         stack[sp] <= pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         PC_new  <= '0;
         valid   <= 1'b0;
         taken   <= 1'b0;
         illegal <= 1'b0;
         sp      <= '0;
         count   <= '0;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         valid   <= ena;
         illegal <= 1'b0;
         if (ena) begin
            PC_new <= pc_inc;
            taken  <= 1'b0;
            case (func)
               C_CALL: begin
                  PC_new <= target;
                  taken  <= 1'b1;
                  sp     <= sp + SP_W'(1);
                  // A full stack wraps over its oldest entry.
                  if (count == C_FULL_CNT) begin
                     ras_ovf <= 1'b1;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
               C_BNO, C_BO, C_BNS, C_BS, C_BNC, C_BC, C_BNZ, C_BZ: begin
                  if (cond_met) begin
                     PC_new <= target;
                     taken  <= 1'b1;
                  end
               end
               C_JMP: begin
                  PC_new <= target;
                  taken  <= 1'b1;
               end
               C_RET: begin
                  if (stack_nonempty) begin
                     PC_new <= stack[sp_m1];
                     taken  <= 1'b1;
                     sp     <= sp_m1;
                     count  <= count - CNT_W'(1);
                  end else begin
                     ras_unf <= 1'b1;
                  end
               end
               C_CLRERR: begin
                  ras_ovf <= 1'b0;
                  ras_unf <= 1'b0;
               end
               default: begin
                  illegal <= 1'b1;
               end
            endcase
         end
      end
   end

   assign ras_empty = ~stack_nonempty;
   assign ras_full  = (count == C_FULL_CNT);
   assign ra_top    = stack_nonempty ? stack[sp_m1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_jump_stack_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_jump_stack_unit                                         |
// | Description : Directed vector bench for jump_stack_unit (RAS_DEPTH=4).   |
// |               An absolute-target instance and a PC-relative instance     |
// |               share one set of inputs.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_jump_stack_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [3:0]  func;
   logic [21:0] addr;
   logic        carryFlag, signFlag, overflowFlag, zeroFlag;
   logic [31:0] PC;

   logic [31:0] a_pc_new, a_ra_top;
   logic        a_valid, a_taken, a_empty, a_full, a_ovf, a_unf, a_illegal;
   logic [31:0] r_pc_new, r_ra_top;
   logic        r_valid, r_taken, r_empty, r_full, r_ovf, r_unf, r_illegal;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   jump_stack_unit #(.ADDR_W(22), .PC_W(32), .RAS_DEPTH(4), .REL_MODE(0)) dut_abs (
      .clk(clk), .rst_n(rst_n), .ena(ena), .func(func), .addr(addr),
      .carryFlag(carryFlag), .signFlag(signFlag), .overflowFlag(overflowFlag),
      .zeroFlag(zeroFlag), .PC(PC), .PC_new(a_pc_new), .valid(a_valid),
      .taken(a_taken), .ra_top(a_ra_top), .ras_empty(a_empty), .ras_full(a_full),
      .ras_ovf(a_ovf), .ras_unf(a_unf), .illegal(a_illegal)
   );

   jump_stack_unit #(.ADDR_W(22), .PC_W(32), .RAS_DEPTH(4), .REL_MODE(1)) dut_rel (
      .clk(clk), .rst_n(rst_n), .ena(ena), .func(func), .addr(addr),
      .carryFlag(carryFlag), .signFlag(signFlag), .overflowFlag(overflowFlag),
      .zeroFlag(zeroFlag), .PC(PC), .PC_new(r_pc_new), .valid(r_valid),
      .taken(r_taken), .ra_top(r_ra_top), .ras_empty(r_empty), .ras_full(r_full),
      .ras_ovf(r_ovf), .ras_unf(r_unf), .illegal(r_illegal)
   );

   // flags field order: {carry, sign, overflow, zero}
   typedef struct {
      string       name;
      logic        rst_n;
      logic        ena;
      logic [3:0]  func;
      logic [21:0] addr;
      logic [3:0]  flags;
      logic [31:0] pc;
      logic [31:0] e_pc_new;
      logic        e_valid, e_taken, e_illegal, e_empty, e_full, e_ovf, e_unf;
      logic [31:0] e_ra_top;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic rn, input logic en,
                      input logic [3:0] fn, input logic [21:0] ad,
                      input logic [3:0] fl, input logic [31:0] pc,
                      input logic [31:0] epc, input logic ev, input logic et,
                      input logic eil, input logic eem, input logic efu,
                      input logic eov, input logic eun, input logic [31:0] era);
      vec_t v;
      v.name = name; v.rst_n = rn; v.ena = en; v.func = fn; v.addr = ad;
      v.flags = fl; v.pc = pc; v.e_pc_new = epc; v.e_valid = ev; v.e_taken = et;
      v.e_illegal = eil; v.e_empty = eem; v.e_full = efu; v.e_ovf = eov;
      v.e_unf = eun; v.e_ra_top = era;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rn, input logic en, input logic [3:0] fn,
                        input logic [21:0] ad, input logic [3:0] fl,
                        input logic [31:0] pc);
      rst_n = rn; ena = en; func = fn; addr = ad;
      {carryFlag, signFlag, overflowFlag, zeroFlag} = fl;
      PC = pc;
   endtask

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   initial begin
      logic [71:0] act, exp;
      drive(1'b0, 1'b0, 4'd0, 22'd0, 4'b0000, 32'd0);

      add("reset",      0,0, 4'd0, 22'd0,  4'b0000, 32'd0,  32'd0,  0,0,0,1,0,0,0, 32'd0);
      // call then return
      add("call25",     1,1, 4'd0, 22'd25, 4'b0000, 32'd1,  32'd25, 1,1,0,0,0,0,0, 32'd2);
      add("ret_to2",    1,1, 4'd10,22'd0,  4'b0000, 32'd30, 32'd2,  1,1,0,1,0,0,0, 32'd0);
      // conditional branches: taken with matching flag, other flags inverted
      add("bno_t",      1,1, 4'd1, 22'd12, 4'b1101, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bno_n",      1,1, 4'd1, 22'd12, 4'b0010, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bo_t",       1,1, 4'd2, 22'd12, 4'b0010, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bo_n",       1,1, 4'd2, 22'd12, 4'b1101, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bns_t",      1,1, 4'd3, 22'd12, 4'b1011, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bns_n",      1,1, 4'd3, 22'd12, 4'b0100, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bs_t",       1,1, 4'd4, 22'd12, 4'b0100, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bs_n",       1,1, 4'd4, 22'd12, 4'b1011, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bnc_t",      1,1, 4'd5, 22'd12, 4'b0111, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bnc_n",      1,1, 4'd5, 22'd12, 4'b1000, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bc_t",       1,1, 4'd6, 22'd12, 4'b1000, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bc_n",       1,1, 4'd6, 22'd12, 4'b0111, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bnz_t",      1,1, 4'd7, 22'd12, 4'b1110, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bnz_n",      1,1, 4'd7, 22'd12, 4'b0001, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      add("bz_t",       1,1, 4'd8, 22'd12, 4'b0001, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("bz_n",       1,1, 4'd8, 22'd12, 4'b1110, 32'd5,  32'd6,  1,0,0,1,0,0,0, 32'd0);
      // jump then idle: outputs hold, valid drops, flags/func ignored
      add("jmp",        1,1, 4'd9, 22'd12, 4'b0000, 32'd5,  32'd12, 1,1,0,1,0,0,0, 32'd0);
      add("idle_hold",  1,0, 4'd10,22'd3,  4'b1111, 32'd77, 32'd12, 0,1,0,1,0,0,0, 32'd0);
      // overflow: five calls into a 4-deep stack
      add("call10",     1,1, 4'd0, 22'd100,4'b0000, 32'd10, 32'd100,1,1,0,0,0,0,0, 32'd11);
      add("call20",     1,1, 4'd0, 22'd100,4'b0000, 32'd20, 32'd100,1,1,0,0,0,0,0, 32'd21);
      add("call30",     1,1, 4'd0, 22'd100,4'b0000, 32'd30, 32'd100,1,1,0,0,0,0,0, 32'd31);
      add("call40",     1,1, 4'd0, 22'd100,4'b0000, 32'd40, 32'd100,1,1,0,0,1,0,0, 32'd41);
      add("call50_ovf", 1,1, 4'd0, 22'd100,4'b0000, 32'd50, 32'd100,1,1,0,0,1,1,0, 32'd51);
      add("ret51",      1,1, 4'd10,22'd0,  4'b0000, 32'd60, 32'd51, 1,1,0,0,0,1,0, 32'd41);
      add("ret41",      1,1, 4'd10,22'd0,  4'b0000, 32'd60, 32'd41, 1,1,0,0,0,1,0, 32'd31);
      add("ret31",      1,1, 4'd10,22'd0,  4'b0000, 32'd60, 32'd31, 1,1,0,0,0,1,0, 32'd21);
      add("ret21",      1,1, 4'd10,22'd0,  4'b0000, 32'd60, 32'd21, 1,1,0,1,0,1,0, 32'd0);
      add("ret_unf",    1,1, 4'd10,22'd0,  4'b0000, 32'd60, 32'd61, 1,0,0,1,0,1,1, 32'd0);
      add("clrerr",     1,1, 4'd11,22'd0,  4'b0000, 32'd70, 32'd71, 1,0,0,1,0,0,0, 32'd0);
      // reserved codes
      add("rsv13",      1,1, 4'd13,22'd9,  4'b0000, 32'd7,  32'd8,  1,0,1,1,0,0,0, 32'd0);
      add("rsv_idle",   1,0, 4'd13,22'd9,  4'b0000, 32'd99, 32'd8,  0,0,0,1,0,0,0, 32'd0);
      add("rsv15_wrap", 1,1, 4'd15,22'd9,  4'b0000, 32'hFFFFFFFF, 32'd0, 1,0,1,1,0,0,0, 32'd0);
      // reset in the middle of a call sequence
      add("callA",      1,1, 4'd0, 22'd5,  4'b0000, 32'd1,  32'd5,  1,1,0,0,0,0,0, 32'd2);
      add("callB",      1,1, 4'd0, 22'd6,  4'b0000, 32'd2,  32'd6,  1,1,0,0,0,0,0, 32'd3);
      add("rst_over",   0,1, 4'd0, 22'd7,  4'b0000, 32'd3,  32'd0,  0,0,0,1,0,0,0, 32'd0);
      add("ret_after",  1,1, 4'd10,22'd0,  4'b0000, 32'd3,  32'd4,  1,0,0,1,0,0,1, 32'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].ena, vecs[i].func, vecs[i].addr,
               vecs[i].flags, vecs[i].pc);
         @(posedge clk);
         #1;
         act = {a_pc_new, a_valid, a_taken, a_illegal, a_empty, a_full,
                a_ovf, a_unf, a_ra_top};
         exp = {vecs[i].e_pc_new, vecs[i].e_valid, vecs[i].e_taken,
                vecs[i].e_illegal, vecs[i].e_empty, vecs[i].e_full,
                vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_ra_top};
         checks++;
         if (act === exp) passes++;
         else $display("FAIL %s: got {pc_new,v,t,il,em,fu,ovf,unf,ra}=%h expected %h",
                       vecs[i].name, act, exp);
      end

      // PC-relative targets on the REL_MODE=1 instance
      drive(1'b1, 1'b1, 4'd9, 22'h3FFFFE, 4'b0000, 32'd100);
      @(posedge clk); #1;
      check32("rel_jmp_neg2", r_pc_new, 32'd98);
      check32("rel_taken", {31'd0, r_taken}, 32'd1);
      check32("abs_jmp_zext", a_pc_new, 32'h003FFFFE);

      drive(1'b1, 1'b1, 4'd9, 22'd1, 4'b0000, 32'hFFFFFFFF);
      @(posedge clk); #1;
      check32("rel_jmp_wrap", r_pc_new, 32'd0);
      check32("abs_jmp_one", a_pc_new, 32'd1);

      // relative call pushes PC+1, target is PC-2
      drive(1'b1, 1'b1, 4'd0, 22'h3FFFFE, 4'b0000, 32'd10);
      @(posedge clk); #1;
      check32("rel_call_tgt", r_pc_new, 32'd8);
      check32("rel_call_ra", r_ra_top, 32'd11);

      drive(1'b1, 1'b1, 4'd10, 22'd0, 4'b0000, 32'd8);
      @(posedge clk); #1;
      check32("rel_ret", r_pc_new, 32'd11);
      check32("rel_ret_empty", {31'd0, r_empty}, 32'd1);

      drive(1'b1, 1'b0, 4'd0, 22'd0, 4'b0000, 32'd0);
      @(posedge clk); #1;
      check32("rel_idle_valid", {31'd0, r_valid}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jump_stack_unit.md
JUMP_STACK_UNIT -- requirements
Module: jump_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 22, width of the branch/call target field.
REQ-002 Parameter PC_W, default 32, width of PC, PC_new, ra_top.
REQ-003 Parameter RAS_DEPTH, default 8, return-address stack entries, power of two, >=2.
REQ-004 Parameter REL_MODE, default 0: 0 = target is addr zero-extended; 1 = target is PC + sign-extended addr, modulo 2^PC_W.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 ena  in  1  request strobe; one jump operation per cycle with ena=1.
REQ-008 func  in  4  operation code (REQ-013).
REQ-009 addr  in  ADDR_W  target field.
REQ-010 carryFlag, signFlag, overflowFlag, zeroFlag  in  1 each  ALU condition flags.
REQ-011 PC  in  PC_W  address of the current instruction.
REQ-012 Outputs: PC_new (PC_W, registered next PC); valid (1, one-cycle result pulse); taken (1, registered); ra_top (PC_W, combinational top of stack, 0 when empty); ras_empty, ras_full (1 each); ras_ovf, ras_unf (1 each, sticky errors); illegal (1, registered pulse).

Function
REQ-013 func: 0 CALL; 1 BNO (ovf=0); 2 BO (ovf=1); 3 BNS (sign=0); 4 BS (sign=1); 5 BNC (carry=0); 6 BC (carry=1); 7 BNZ (zero=0); 8 BZ (zero=1); 9 JMP; 10 RET; 11 CLRERR; 12-15 reserved.
REQ-014 Latency one cycle: operation sampled at edge N with ena=1 -> PC_new, taken, valid=1 visible after edge N; valid low after any edge with ena=0.
REQ-015 With ena=0, PC_new, taken, stack and sticky flags hold; valid=0, illegal=0.
REQ-016 Taken branch/JMP/CALL: PC_new = target (REQ-004), taken=1; untaken conditional: PC_new = PC+1, taken=0.
REQ-017 CALL pushes PC+1 into stack slot sp, sp = (sp+1) mod RAS_DEPTH, count = min(count+1, RAS_DEPTH).
REQ-018 CALL when count==RAS_DEPTH: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_ovf set to 1; PC_new = target as normal.
REQ-019 RET with count>0: PC_new = slot (sp-1) mod RAS_DEPTH, taken=1, sp decrements modulo, count-1.
REQ-020 RET with count==0: PC_new = PC+1, taken=0, ras_unf set to 1, sp/count unchanged.
REQ-021 CLRERR: clears ras_ovf and ras_unf, PC_new = PC+1, taken=0, stack unchanged.
REQ-022 Reserved func: PC_new = PC+1, taken=0, illegal=1 for that result cycle, no stack change.
REQ-023 ras_empty = (count==0), ras_full = (count==RAS_DEPTH), ra_top = slot (sp-1) when count>0 else 0; all derived from registered state.
REQ-024 PC+1 and PC+offset wrap modulo 2^PC_W; ADDR_W > PC_W truncates target to PC_W LSBs.
REQ-025 Flags are sampled in the same cycle as ena; flag changes with ena=0 have no effect.
REQ-026 Back-to-back CALL/RET on consecutive cycles is supported; each sees the stack state produced by the previous cycle.

Reset
REQ-027 rst_n=0 at an edge: PC_new=0, valid=0, taken=0, illegal=0, sp=0, count=0, ras_ovf=0, ras_unf=0; stack contents need not be cleared but are unobservable (ra_top=0).
REQ-028 rst_n=0 overrides ena in the same cycle; a reset mid-sequence discards all pending stack entries.

Verification (RAS_DEPTH=4, PC_W=32, REL_MODE=0 unless noted)
REQ-029 CALL addr=25 PC=1, then RET PC=30 -> PC_new=25 taken=1, then PC_new=2 taken=1, ras_empty=1.
REQ-030 Each of func 1-8 with matching flag then inverted flag, addr=12 PC=5 -> PC_new=12 taken=1, then PC_new=6 taken=0.
REQ-031 Five CALLs PC=10,20,30,40,50 -> ras_full=1, ras_ovf=1; four RETs return 51,41,31,21; fifth RET -> PC_new=PC+1, ras_unf=1; CLRERR clears both.
REQ-032 REL_MODE=1, JMP addr=0x3FFFFE (-2) PC=100 -> PC_new=98; PC=0xFFFFFFFF, addr=1 -> PC_new=0.
REQ-033 func=13 PC=7 -> PC_new=8, illegal=1 one cycle; ena=0 next -> valid=0, PC_new holds 8.
REQ-034 Two CALLs then rst_n=0 with ena=1 -> all outputs at reset values, ra_top=0; following RET -> ras_unf=1.
